// File: rtl/kronos_dmem_bridge.sv
// kronos_dmem_bridge
//   Bridges the Kronos LSU data bus (request held until a one-cycle ack)
//   onto a synchronous single-port SRAM with a fixed read latency and an
//   optional number of idle cycles before every access. A request whose
//   address falls outside the SRAM window is not issued to the SRAM; it is
//   acked with data_err instead.
//
// Ports
//   clk, rstz            core clock, asynchronous active-low reset
//   data_addr            LSU byte address (bits [1:0] ignored)
//   data_wr_data         LSU store data
//   data_mask            LSU byte-lane write enables
//   data_wr_en           1 = store, 0 = load
//   data_req             LSU request, held until data_ack
//   data_ack             one-cycle completion pulse
//   data_rd_data         registered load data, valid with data_ack of a load
//   data_err             out-of-window flag, coincident with data_ack
//   mem_en, mem_we       SRAM strobe / write enable (high only in ISSUE)
//   mem_addr             SRAM word address
//   mem_wdata, mem_wmask SRAM write data / byte mask
//   mem_rdata            SRAM read data, valid MEM_LATENCY cycles after mem_en
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for data_req; request payload captured on accept
// WAIT   | WAIT_STATES idle cycles before the SRAM access
// ISSUE  | one-cycle SRAM access (suppressed when out of window)
// RDWAIT | waiting MEM_LATENCY cycles for mem_rdata
// ACK    | one-cycle data_ack (and data_err) back to the LSU

module kronos_dmem_bridge #(
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          MEM_LATENCY = 1,
    parameter int          WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rstz,
    input  logic [31:0]                   data_addr,
    input  logic [31:0]                   data_wr_data,
    input  logic [3:0]                    data_mask,
    input  logic                          data_wr_en,
    input  logic                          data_req,
    output logic                          data_ack,
    output logic [31:0]                   data_rd_data,
    output logic                          data_err,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [$clog2(MEM_WORDS)-1:0]  mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic [3:0]                    mem_wmask,
    input  logic [31:0]                   mem_rdata
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [2:0]  WS_LD     = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [2:0]  LAT_LD    = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ISSUE  = 3'd2,
        RDWAIT = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    cnt;
    logic [AW-1:0] off_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic          wr_q;
    logic          inr_q;

    // Window check uses the wrapped 32b offset, so addresses below MEM_BASE
    // land far above the window and are rejected too.
    logic [31:0] offset_in;
    logic        inr_in;
    assign offset_in = data_addr - MEM_BASE;
    assign inr_in    = {1'b0, offset_in} < WIN_BYTES;

    // The SRAM outputs are registered on the edge that enters ISSUE. With no
    // wait states that edge is the same one that captures the request, so
    // the payload is taken straight from the bus in IDLE.
    logic          from_bus;
    logic [AW-1:0] addr_sel;
    logic [31:0]   wdata_sel;
    logic [3:0]    mask_sel;
    logic          wr_sel;
    logic          inr_sel;
    logic          issue_ld;

    assign from_bus  = (state == IDLE);
    assign addr_sel  = from_bus ? offset_in[AW+1:2] : off_q;
    assign wdata_sel = from_bus ? data_wr_data : wdata_q;
    assign mask_sel  = from_bus ? data_mask : mask_q;
    assign wr_sel    = from_bus ? data_wr_en : wr_q;
    assign inr_sel   = from_bus ? inr_in : inr_q;
    assign issue_ld  = (state_nxt == ISSUE);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_ack  = 1'b0;
        data_err  = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ISSUE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = (inr_q && !wr_q) ? RDWAIT : ACK;
            end
            RDWAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                data_ack  = 1'b1;
                data_err  = !inr_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared down-counter: wait states, then read latency.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt <= 3'd0;
        end else begin
            case (state)
                IDLE:        if (data_req) cnt <= WS_LD;
                ISSUE:       cnt <= LAT_LD;
                WAIT,
                RDWAIT:      if (cnt != 3'd0) cnt <= cnt - 3'd1;
                default:     cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            off_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            inr_q   <= 1'b0;
        end else if (state == IDLE && data_req) begin
            off_q   <= offset_in[AW+1:2];
            wdata_q <= data_wr_data;
            mask_q  <= data_mask;
            wr_q    <= data_wr_en;
            inr_q   <= inr_in;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (issue_ld && inr_sel) begin
                mem_en   <= 1'b1;
                mem_we   <= wr_sel;
                mem_addr <= addr_sel;
                if (wr_sel) begin
                    mem_wdata <= wdata_sel;
                    mem_wmask <= mask_sel;
                end else begin
                    mem_wmask <= 4'b0000;
                end
            end
        end
    end

    // Load data is only replaced by a completed load; a rejected load
    // returns zero, stores leave it alone.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            data_rd_data <= '0;
        end else if (state == RDWAIT && cnt == 3'd0) begin
            data_rd_data <= mem_rdata;
        end else if (state == ISSUE && !inr_q && !wr_q) begin
            data_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_kronos_dmem_bridge.sv
// Bench for kronos_dmem_bridge. Three bridges run side by side:
//   0: defaults (base 0, latency 1, no wait states)
//   1: latency 3, two wait states
//   2: base 0x1000, latency 1, no wait states
// Each has its own SRAM model. A small model predicts every transaction
// into a queue; the transaction is then driven and the prediction popped
// and compared with what the bridge did.

module tb_kronos_dmem_bridge;

    logic clk  = 1'b0;
    logic rstz = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] addr_a  [3];
    logic [31:0] wd_a    [3];
    logic [3:0]  mask_a  [3];
    logic        wr_a    [3];
    logic        req_a   [3];
    logic        ack_a   [3];
    logic [31:0] rd_a    [3];
    logic        err_a   [3];
    logic        en_a    [3];
    logic        we_a    [3];
    logic [9:0]  ma_a    [3];
    logic [31:0] mwd_a   [3];
    logic [3:0]  mwm_a   [3];
    logic [31:0] mrd_a   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [31:0] B = (g == 2) ? 32'h1000 : 32'h0;
        localparam int          L = (g == 1) ? 3 : 1;
        localparam int          W = (g == 1) ? 2 : 0;

        kronos_dmem_bridge #(
            .MEM_BASE(B), .MEM_WORDS(1024), .MEM_LATENCY(L), .WAIT_STATES(W)
        ) u_dut (
            .clk(clk), .rstz(rstz),
            .data_addr(addr_a[g]), .data_wr_data(wd_a[g]), .data_mask(mask_a[g]),
            .data_wr_en(wr_a[g]), .data_req(req_a[g]), .data_ack(ack_a[g]),
            .data_rd_data(rd_a[g]), .data_err(err_a[g]),
            .mem_en(en_a[g]), .mem_we(we_a[g]), .mem_addr(ma_a[g]),
            .mem_wdata(mwd_a[g]), .mem_wmask(mwm_a[g]), .mem_rdata(mrd_a[g])
        );

        // SRAM: data appears L cycles after the read strobe, junk otherwise.
        logic [31:0] sram [1024];
        logic [31:0] pipe [4];
        always @(posedge clk) begin
            for (int k = 3; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= 32'hBAD0_BAD0;
            if (en_a[g]) begin
                if (we_a[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mwm_a[g][b]) sram[ma_a[g]][8*b +: 8] <= mwd_a[g][8*b +: 8];
                end else begin
                    pipe[0] <= sram[ma_a[g]];
                end
            end
        end
        assign mrd_a[g] = pipe[L-1];
    end

    // Bus monitor
    int          en_cnt   [3] = '{0, 0, 0};
    int          ack_cnt  [3] = '{0, 0, 0};
    int          en_cyc_l [3];
    logic [9:0]  en_addr_l[3];
    logic [3:0]  en_wm_l  [3];
    logic [31:0] en_wd_l  [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en_a[i] === 1'b1) begin
                en_cnt[i]++;
                en_cyc_l[i]  = cyc;
                en_addr_l[i] = ma_a[i];
                en_wm_l[i]   = mwm_a[i];
                en_wd_l[i]   = mwd_a[i];
            end
            if (ack_a[i] === 1'b1) ack_cnt[i]++;
        end
    end

    typedef struct {
        int          ack_cyc;
        logic [31:0] rd;
        logic        err;
        int          n_en;
        int          n_ack;
        int          en_cyc;
        logic [9:0]  maddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        w;
    } stim_t;

    txn_t        exp_q[$];
    logic [31:0] shadow [3][1024];
    logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] base_of(int i);
        return (i == 2) ? 32'h1000 : 32'h0;
    endfunction
    function automatic int lat_of(int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic int ws_of(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    task automatic predict(input int i, input stim_t s, input int t);
        txn_t        e;
        logic [31:0] off;
        logic        inr;
        off       = s.a - base_of(i);
        inr       = off < 32'd4096;
        e.en_cyc  = t + 1 + ws_of(i);
        e.maddr   = off[11:2];
        e.n_en    = inr ? 1 : 0;
        e.n_ack   = 1;
        e.err     = !inr;
        e.wmask   = s.w ? s.m : 4'b0000;
        e.wdata   = s.d;
        if (!inr) begin
            e.ack_cyc = t + 2 + ws_of(i);
            if (!s.w) last_rd[i] = 32'h0;
        end else if (s.w) begin
            e.ack_cyc = t + 2 + ws_of(i);
            for (int b = 0; b < 4; b++)
                if (s.m[b]) shadow[i][off[11:2]][8*b +: 8] = s.d[8*b +: 8];
        end else begin
            e.ack_cyc  = t + 2 + ws_of(i) + lat_of(i);
            last_rd[i] = shadow[i][off[11:2]];
        end
        e.rd = last_rd[i];
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following ack.
    task automatic drive(input int i, input stim_t s, output txn_t o);
        int n_en0, n_ack0;
        n_en0     = en_cnt[i];
        n_ack0    = ack_cnt[i];
        o.ack_cyc = -1;
        o.rd      = 'x;
        o.err     = 1'bx;
        addr_a[i] = s.a;
        wd_a[i]   = s.d;
        mask_a[i] = s.m;
        wr_a[i]   = s.w;
        req_a[i]  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_a[i] === 1'b1) begin
                o.ack_cyc = cyc;
                o.rd      = rd_a[i];
                o.err     = err_a[i];
                break;
            end
        end
        @(posedge clk);
        #1;
        req_a[i] = 1'b0;
        o.n_en   = en_cnt[i] - n_en0;
        o.n_ack  = ack_cnt[i] - n_ack0;
        o.en_cyc = en_cyc_l[i];
        o.maddr  = en_addr_l[i];
        o.wmask  = en_wm_l[i];
        o.wdata  = en_wd_l[i];
    endtask

    task automatic test_reset();
        #23;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ack_a[i], err_a[i], en_a[i], we_a[i]} !== 4'b0 || rd_a[i] !== 32'h0 ||
                ma_a[i] !== 10'h0 || mwd_a[i] !== 32'h0 || mwm_a[i] !== 4'h0) begin
                errors++;
                $display("FAIL reset[%0d] ack=%b err=%b en=%b we=%b rd=%h ma=%h wd=%h wm=%h, need all zero",
                         i, ack_a[i], err_a[i], en_a[i], we_a[i], rd_a[i], ma_a[i], mwd_a[i], mwm_a[i]);
            end
        end
        @(negedge clk);
        rstz = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        stim_t tbl[3] = '{'{32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1},
                          '{32'h10, 32'h0,         4'hF, 1'b0},
                          '{32'h14, 32'h0123_4567, 4'hF, 1'b1}};
        txn_t e, o;
        foreach (tbl[k]) begin
            predict(0, tbl[k], cyc);
            drive(0, tbl[k], o);
            e = exp_q.pop_front();
            checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.rd !== e.rd || o.n_en !== e.n_en || o.n_ack !== e.n_ack) begin
                errors++;
                $display("FAIL wr_rd[%0d] got ack@%0d err=%b rd=%h en=%0d acks=%0d, need ack@%0d err=%b rd=%h en=%0d acks=%0d",
                         k, o.ack_cyc, o.err, o.rd, o.n_en, o.n_ack, e.ack_cyc, e.err, e.rd, e.n_en, e.n_ack);
            end
            if (e.n_en == 1) begin
                checks++;
                if (o.en_cyc !== e.en_cyc || o.maddr !== e.maddr || o.wmask !== e.wmask || (e.wmask != 0 && o.wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL wr_rd_mem[%0d] got en@%0d addr=%0d wm=%b wd=%h, need en@%0d addr=%0d wm=%b wd=%h",
                             k, o.en_cyc, o.maddr, o.wmask, o.wdata, e.en_cyc, e.maddr, e.wmask, e.wdata);
                end
            end
        end
    endtask

    task automatic test_byte_store();
        stim_t tbl[3] = '{'{32'h13, 32'h5A00_0000, 4'b1000, 1'b1},
                          '{32'h10, 32'h0,         4'hF,    1'b0},
                          '{32'h15, 32'h0000_9900, 4'b0010, 1'b1}};
        txn_t e, o;
        foreach (tbl[k]) begin
            predict(0, tbl[k], cyc);
            drive(0, tbl[k], o);
            e = exp_q.pop_front();
            checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.rd !== e.rd || o.n_en !== e.n_en || o.n_ack !== e.n_ack) begin
                errors++;
                $display("FAIL byte[%0d] got ack@%0d err=%b rd=%h en=%0d acks=%0d, need ack@%0d err=%b rd=%h en=%0d acks=%0d",
                         k, o.ack_cyc, o.err, o.rd, o.n_en, o.n_ack, e.ack_cyc, e.err, e.rd, e.n_en, e.n_ack);
            end
            checks++;
            if (o.en_cyc !== e.en_cyc || o.maddr !== e.maddr || o.wmask !== e.wmask || (e.wmask != 0 && o.wdata !== e.wdata)) begin
                errors++;
                $display("FAIL byte_mem[%0d] got en@%0d addr=%0d wm=%b wd=%h, need en@%0d addr=%0d wm=%b wd=%h",
                         k, o.en_cyc, o.maddr, o.wmask, o.wdata, e.en_cyc, e.maddr, e.wmask, e.wdata);
            end
        end
    endtask

    task automatic test_latency();
        stim_t tbl[3] = '{'{32'h40, 32'hCAFE_F00D, 4'hF, 1'b1},
                          '{32'h40, 32'h0,         4'hF, 1'b0},
                          '{32'h44, 32'h0,         4'hF, 1'b1}};
        txn_t e, o;
        foreach (tbl[k]) begin
            predict(1, tbl[k], cyc);
            drive(1, tbl[k], o);
            e = exp_q.pop_front();
            checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.rd !== e.rd || o.n_en !== e.n_en || o.n_ack !== e.n_ack) begin
                errors++;
                $display("FAIL latency[%0d] got ack@%0d err=%b rd=%h en=%0d acks=%0d, need ack@%0d err=%b rd=%h en=%0d acks=%0d",
                         k, o.ack_cyc, o.err, o.rd, o.n_en, o.n_ack, e.ack_cyc, e.err, e.rd, e.n_en, e.n_ack);
            end
            checks++;
            if (o.en_cyc !== e.en_cyc || o.maddr !== e.maddr || o.wmask !== e.wmask) begin
                errors++;
                $display("FAIL latency_mem[%0d] got en@%0d addr=%0d wm=%b, need en@%0d addr=%0d wm=%b",
                         k, o.en_cyc, o.maddr, o.wmask, e.en_cyc, e.maddr, e.wmask);
            end
        end
    endtask

    task automatic test_out_of_range();
        stim_t tbl[7] = '{'{32'h1FFC, 32'h1234_5678, 4'hF, 1'b1},
                          '{32'h1FFC, 32'h0,         4'hF, 1'b0},
                          '{32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b1},
                          '{32'h2000, 32'h0,         4'hF, 1'b0},
                          '{32'h1000, 32'hA5A5_0001, 4'hF, 1'b1},
                          '{32'h0FFC, 32'h0,         4'hF, 1'b0},
                          '{32'h1000, 32'h0,         4'hF, 1'b0}};
        txn_t e, o;
        foreach (tbl[k]) begin
            predict(2, tbl[k], cyc);
            drive(2, tbl[k], o);
            e = exp_q.pop_front();
            checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.rd !== e.rd || o.n_en !== e.n_en || o.n_ack !== e.n_ack) begin
                errors++;
                $display("FAIL range[%0d] got ack@%0d err=%b rd=%h en=%0d acks=%0d, need ack@%0d err=%b rd=%h en=%0d acks=%0d",
                         k, o.ack_cyc, o.err, o.rd, o.n_en, o.n_ack, e.ack_cyc, e.err, e.rd, e.n_en, e.n_ack);
            end
            if (e.n_en == 1) begin
                checks++;
                if (o.en_cyc !== e.en_cyc || o.maddr !== e.maddr || o.wmask !== e.wmask) begin
                    errors++;
                    $display("FAIL range_mem[%0d] got en@%0d addr=%0d wm=%b, need en@%0d addr=%0d wm=%b",
                             k, o.en_cyc, o.maddr, o.wmask, e.en_cyc, e.maddr, e.wmask);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[3] = '{'{32'h0, 32'h1111_1111, 4'hF, 1'b1},
                          '{32'h4, 32'h2222_2222, 4'hF, 1'b1},
                          '{32'h8, 32'h3333_3333, 4'hF, 1'b1}};
        txn_t e, o;
        int   ack_at[3];
        foreach (tbl[k]) begin
            predict(0, tbl[k], cyc);
            drive(0, tbl[k], o);
            ack_at[k] = o.ack_cyc;
            e = exp_q.pop_front();
            checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.n_en !== e.n_en || o.n_ack !== e.n_ack ||
                o.maddr !== e.maddr || o.wdata !== e.wdata || o.en_cyc !== e.en_cyc) begin
                errors++;
                $display("FAIL b2b[%0d] got ack@%0d err=%b en=%0d acks=%0d en@%0d addr=%0d wd=%h, need ack@%0d err=%b en=%0d acks=%0d en@%0d addr=%0d wd=%h",
                         k, o.ack_cyc, o.err, o.n_en, o.n_ack, o.en_cyc, o.maddr, o.wdata,
                         e.ack_cyc, e.err, e.n_en, e.n_ack, e.en_cyc, e.maddr, e.wdata);
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (ack_at[k] - ack_at[k-1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing[%0d] got %0d cycles, need 3", k, ack_at[k] - ack_at[k-1]);
            end
        end
    endtask

    task automatic test_reset_rdwait();
        stim_t s = '{32'h40, 32'h0, 4'hF, 1'b0};
        txn_t  e, o;
        int    n_ack0;
        addr_a[1] = s.a;
        wd_a[1]   = s.d;
        mask_a[1] = s.m;
        wr_a[1]   = s.w;
        req_a[1]  = 1'b1;
        n_ack0    = ack_cnt[1];
        // ISSUE at T+3, RDWAIT spans T+4..T+6; reset lands inside T+5.
        repeat (5) @(posedge clk);
        #2;
        rstz = 1'b0;
        #1;
        checks++;
        if (ack_a[1] !== 1'b0 || en_a[1] !== 1'b0 || rd_a[1] !== 32'h0 || ma_a[1] !== 10'h0 || mwm_a[1] !== 4'h0) begin
            errors++;
            $display("FAIL rst_rdwait_out got ack=%b en=%b rd=%h ma=%h wm=%h, need all zero",
                     ack_a[1], en_a[1], rd_a[1], ma_a[1], mwm_a[1]);
        end
        req_a[1] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ack_cnt[1] - n_ack0 != 0) begin
            errors++;
            $display("FAIL rst_rdwait_noack got %0d acks, need 0", ack_cnt[1] - n_ack0);
        end
        rstz = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
        @(posedge clk);
        #1;
        predict(1, s, cyc);
        drive(1, s, o);
        e = exp_q.pop_front();
        checks++;
        if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.rd !== e.rd || o.n_en !== e.n_en || o.n_ack !== e.n_ack) begin
            errors++;
            $display("FAIL rst_rdwait_after got ack@%0d err=%b rd=%h en=%0d acks=%0d, need ack@%0d err=%b rd=%h en=%0d acks=%0d",
                     o.ack_cyc, o.err, o.rd, o.n_en, o.n_ack, e.ack_cyc, e.err, e.rd, e.n_en, e.n_ack);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr_a[i] = 32'h0;
            wd_a[i]   = 32'h0;
            mask_a[i] = 4'h0;
            wr_a[i]   = 1'b0;
            req_a[i]  = 1'b0;
        end
        test_reset();
        test_write_read();
        test_byte_store();
        test_latency();
        test_out_of_range();
        test_back_to_back();
        test_reset_rdwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d, need completion earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
